// File: rtl/vcxo_dac_pkg.sv
// rtl/vcxo_dac_pkg.sv - shared constants, FSM states and frame builder for the VCXO DAC arbiter
package vcxo_dac_pkg;
   localparam int FRAME_BITS = 24;
   localparam logic [1:0] PD_NORMAL = 2'b00;

   typedef enum logic [1:0] {INIT, IDLE, SHIFT, GAP} state_t;

   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [15:0] code);
      return {6'b000000, PD_NORMAL, code};
   endfunction
endpackage

// File: rtl/vcxo_dac_arbiter_if.sv
// rtl/vcxo_dac_arbiter_if.sv - requester handshakes and AD5662 serial bus of the VCXO DAC arbiter
interface vcxo_dac_arbiter_if;
   logic        loop_valid;
   logic [15:0] loop_dat;
   logic        loop_ready;
   logic        host_valid;
   logic [15:0] host_dat;
   logic        host_ready;
   logic        host_lock;
   logic        sclk;
   logic        mosi;
   logic        sync_n;
   logic        busy;
   logic [15:0] last_dat;

   modport master (
      output loop_valid, loop_dat, host_valid, host_dat, host_lock,
      input  loop_ready, host_ready, sclk, mosi, sync_n, busy, last_dat
   );

   modport slave (
      input  loop_valid, loop_dat, host_valid, host_dat, host_lock,
      output loop_ready, host_ready, sclk, mosi, sync_n, busy, last_dat
   );
endinterface

// File: rtl/vcxo_dac_spi_shift.sv
// rtl/vcxo_dac_spi_shift.sv - shifts one 24-bit AD5662 frame; sync_n low for 1 + 48*CLK_DIV cycles
module vcxo_dac_spi_shift
   import vcxo_dac_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] frame,
   output logic                  done,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  sync_n
);
   localparam logic [7:0] DIV_LD    = 8'(CLK_DIV);
   localparam logic [7:0] DIV_RL    = 8'(CLK_DIV - 1);
   localparam logic [5:0] LAST_EDGE = 6'(2 * FRAME_BITS - 1);

   logic                  active;
   logic [FRAME_BITS-1:0] shreg;
   logic [7:0]            div_cnt;
   logic [5:0]            edge_cnt;

   // The first half-period is one cycle longer: that cycle is the sync_n setup time.
   always_ff @(posedge clk) begin
      if (reset) begin
         active   <= 1'b0;
         sync_n   <= 1'b1;
         sclk     <= 1'b1;
         mosi     <= 1'b0;
         shreg    <= '0;
         div_cnt  <= '0;
         edge_cnt <= '0;
      end else if (!active) begin
         if (start) begin
            active   <= 1'b1;
            sync_n   <= 1'b0;
            mosi     <= frame[FRAME_BITS-1];
            shreg    <= {frame[FRAME_BITS-2:0], 1'b0};
            div_cnt  <= DIV_LD;
            edge_cnt <= '0;
         end
      end else if (div_cnt != 8'd0) begin
         div_cnt <= div_cnt - 8'd1;
      end else begin
         div_cnt  <= DIV_RL;
         edge_cnt <= edge_cnt + 6'd1;
         if (edge_cnt == LAST_EDGE) begin
            active <= 1'b0;
            sync_n <= 1'b1;
            sclk   <= 1'b1;
            mosi   <= 1'b0;
         end else begin
            sclk <= ~sclk;
            if (!sclk) begin
               mosi  <= shreg[FRAME_BITS-1];
               shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
         end
      end
   end

   assign done = active && (div_cnt == 8'd0) && (edge_cnt == LAST_EDGE);
endmodule

// File: rtl/vcxo_dac_arbiter.sv
// rtl/vcxo_dac_arbiter.sv - round-robin host/loop arbiter driving an AD5662 VCXO DAC
// Optional VCXO_DAC_COALESCE_EN: loop side becomes a 1-entry overwrite register.
module vcxo_dac_arbiter
   import vcxo_dac_pkg::*;
#(
   parameter int          CLK_DIV = 4,
   parameter int          GAP_CYC = 8,
   parameter logic [15:0] DFLT    = 16'h7FFF
) (
   input logic               clk,
   input logic               reset,
   vcxo_dac_arbiter_if.slave bus
);
   localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);

   state_t                state;
   logic                  last_loop;
   logic [15:0]           cur_dat;
   logic [15:0]           last_dat_q;
   logic [7:0]            gap_cnt;
   logic                  busy_q;
   logic                  loop_req;
   logic [15:0]           loop_code;
   logic                  idle;
   logic                  host_elig;
   logic                  loop_elig;
   logic                  grant_host;
   logic                  grant_loop;
   logic                  start;
   logic                  done;
   logic [15:0]           start_code;
   logic [FRAME_BITS-1:0] start_frame;

`ifdef VCXO_DAC_COALESCE_EN
   logic        pend_v;
   logic [15:0] pend_dat;

   // A write in the grant cycle re-arms pending; the grant itself takes the older value.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_v   <= 1'b0;
         pend_dat <= '0;
      end else if (bus.loop_valid) begin
         pend_v   <= 1'b1;
         pend_dat <= bus.loop_dat;
      end else if (grant_loop) begin
         pend_v <= 1'b0;
      end
   end

   assign loop_req       = pend_v;
   assign loop_code      = pend_dat;
   assign bus.loop_ready = !reset;
`else
   assign loop_req       = bus.loop_valid;
   assign loop_code      = bus.loop_dat;
   assign bus.loop_ready = grant_loop;
`endif

   assign idle       = (state == IDLE) && !reset;
   assign host_elig  = idle && bus.host_valid;
   assign loop_elig  = idle && loop_req && !bus.host_lock;
   assign grant_host = host_elig && (!loop_elig || last_loop);
   assign grant_loop = loop_elig && !grant_host;

   assign bus.host_ready = grant_host;
   assign start          = ((state == INIT) && !reset) || grant_host || grant_loop;
   assign start_code     = (state == INIT) ? DFLT : (grant_host ? bus.host_dat : loop_code);
   assign start_frame    = make_frame(start_code);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         last_loop  <= 1'b1;
         cur_dat    <= DFLT;
         last_dat_q <= DFLT;
         gap_cnt    <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               cur_dat <= DFLT;
               state   <= SHIFT;
            end
            IDLE: begin
               if (grant_host || grant_loop) begin
                  cur_dat <= start_code;
                  state   <= SHIFT;
                  busy_q  <= 1'b1;
                  if (!bus.host_lock) last_loop <= grant_loop;
               end
            end
            SHIFT: begin
               if (done) begin
                  last_dat_q <= cur_dat;
                  gap_cnt    <= GAP_LD;
                  state      <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == 8'd0) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   assign bus.busy     = busy_q || reset;
   assign bus.last_dat = last_dat_q;

   vcxo_dac_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .frame  (start_frame),
      .done   (done),
      .sclk   (bus.sclk),
      .mosi   (bus.mosi),
      .sync_n (bus.sync_n)
   );
endmodule

// File: tb/tb_vcxo_dac_arbiter.sv
// tb/tb_vcxo_dac_arbiter.sv - scoreboard bench for vcxo_dac_arbiter (VCXO_DAC_COALESCE_EN selects coalesce scenarios)
module tb_vcxo_dac_arbiter;
   localparam int          CLK_DIV = 4;
   localparam int          GAP_CYC = 8;
   localparam logic [15:0] DFLT    = 16'h7FFF;

   logic clk = 1'b0;
   logic reset = 1'b1;

   vcxo_dac_arbiter_if bus();

   vcxo_dac_arbiter #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .DFLT(DFLT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];
   logic [15:0] hq[$];
   logic [15:0] lq[$];
   bit          m_last_loop;
   int          host_wait, loop_wait, loop_sent;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   // Frame monitor: decode each sync_n-low window and score it against the next expected code.
   initial begin : monitor
      bit          in_frame;
      bit          gap_watch;
      int          low_cnt, nbits, gap_cnt;
      logic [23:0] bits;
      logic        prev_sclk;
      logic [15:0] e;
      in_frame = 0;
      gap_watch = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (in_frame && exp_q.size() > 0) e = exp_q.pop_front();
            in_frame = 0;
            gap_watch = 0;
            continue;
         end
         if (gap_watch) begin
            if (bus.busy) gap_cnt++;
            else begin
               check("gap_len", 32'(gap_cnt), 32'(GAP_CYC));
               gap_watch = 0;
            end
         end
         if (!in_frame && !bus.sync_n) begin
            in_frame = 1;
            low_cnt = 0;
            nbits = 0;
            bits = '0;
            prev_sclk = 1'b1;
         end
         if (in_frame) begin
            if (!bus.sync_n) begin
               low_cnt++;
               if (prev_sclk && !bus.sclk) begin
                  bits = {bits[22:0], bus.mosi};
                  nbits++;
               end
               prev_sclk = bus.sclk;
            end else begin
               in_frame = 0;
               if (exp_q.size() == 0) begin
                  timeout("frame_unexpected");
               end else begin
                  e = exp_q.pop_front();
                  check("frame_bits", 32'(bits), {16'h0000, e});
                  check("frame_nbits", 32'(nbits), 32'd24);
                  check("sync_low_cycles", 32'(low_cnt), 32'(1 + 48 * CLK_DIV));
                  check("last_dat", 32'(bus.last_dat), 32'(e));
               end
               gap_watch = 1;
               gap_cnt = 1;
            end
         end
      end
   end

`ifndef VCXO_DAC_COALESCE_EN
   always @(negedge clk)
      if (!reset && bus.host_lock) check("loop_ready_locked", 32'(bus.loop_ready), 32'd0);
`endif

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_host();
      int t;
      @(posedge clk); #1;
      while (hq.size() > 0) begin
         bus.host_dat = hq.pop_front();
         bus.host_valid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!bus.host_ready && t < 3000);
         host_wait = t;
         if (!bus.host_ready) begin timeout("host_ready"); break; end
         @(posedge clk); #1;
         bus.host_valid = (hq.size() > 0);
         if (hq.size() > 0) bus.host_dat = hq[0];
         @(negedge clk);
         check("host_ready_pulse", 32'(bus.host_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.host_valid = 1'b0;
   endtask

   task automatic drive_loop();
      int t;
      @(posedge clk); #1;
      while (lq.size() > 0) begin
         bus.loop_dat = lq.pop_front();
         bus.loop_valid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!bus.loop_ready && t < 3000);
         loop_wait = t;
         if (!bus.loop_ready) begin timeout("loop_ready"); break; end
         @(posedge clk); #1;
         loop_sent++;
         bus.loop_valid = (lq.size() > 0);
         if (lq.size() > 0) bus.loop_dat = lq[0];
`ifndef VCXO_DAC_COALESCE_EN
         @(negedge clk);
         check("loop_ready_pulse", 32'(bus.loop_ready), 32'd0);
         @(posedge clk); #1;
`endif
      end
      bus.loop_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      do begin @(negedge clk); t++; end while ((bus.busy || exp_q.size() != 0) && t < 5000);
      if (t >= 5000) timeout(name);
   endtask

   // Reference order when both ports hold requests: alternate, host wins while locked.
   task automatic model_held(input bit lock);
      int hi = 0;
      int li = 0;
      bit pick_loop;
      while (hi < hq.size() || li < lq.size()) begin
         pick_loop = !(hi < hq.size() && (li >= lq.size() || lock || m_last_loop));
         if (pick_loop) begin exp_q.push_back(lq[li]); li++; end
         else begin exp_q.push_back(hq[hi]); hi++; end
         if (!lock || pick_loop) m_last_loop = pick_loop;
      end
   endtask

   task automatic random_singles(input int n);
      bit          use_loop;
      bit          lock;
      logic [15:0] code;
      for (int i = 0; i < n; i++) begin
         use_loop = 1'($urandom_range(0, 1));
         code = 16'($urandom);
         lock = use_loop ? 1'b0 : 1'($urandom_range(0, 1));
         bus.host_lock = lock;
         exp_q.push_back(code);
         if (!lock) m_last_loop = use_loop;
         if (use_loop) begin
            lq.push_back(code);
            drive_loop();
            check("loop_latency", 32'(loop_wait), 32'd1);
         end else begin
            hq.push_back(code);
            drive_host();
            check("host_latency", 32'(host_wait), 32'd1);
         end
         wait_idle("single_idle");
         bus.host_lock = 1'b0;
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_sync_n"}, 32'(bus.sync_n), 32'd1);
      check({tag, "_sclk"}, 32'(bus.sclk), 32'd1);
      check({tag, "_mosi"}, 32'(bus.mosi), 32'd0);
      check({tag, "_host_ready"}, 32'(bus.host_ready), 32'd0);
      check({tag, "_loop_ready"}, 32'(bus.loop_ready), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_last_dat"}, 32'(bus.last_dat), 32'(DFLT));
   endtask

   initial begin
      int t;
      bus.loop_valid = 1'b1;
      bus.loop_dat = 16'h5555;
      bus.host_valid = 1'b1;
      bus.host_dat = 16'hAAAA;
      bus.host_lock = 1'b0;
      m_last_loop = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks("rst");
      bus.loop_valid = 1'b0;
      bus.host_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.push_back(DFLT);

`ifdef VCXO_DAC_COALESCE_EN
      t = 0;
      do begin @(negedge clk); t++; end while (bus.sync_n && t < 100);
      for (int v = 1; v <= 3; v++) begin
         @(posedge clk); #1;
         bus.loop_valid = 1'b1;
         bus.loop_dat = 16'(v);
      end
      @(posedge clk); #1;
      bus.loop_valid = 1'b0;
      exp_q.push_back(16'h0003);
      m_last_loop = 1'b1;
      wait_idle("coalesce_idle");
      random_singles(8);
`else
      wait_idle("dflt_idle");
      random_singles(10);

      repeat (3) begin hq.push_back(16'($urandom)); lq.push_back(16'($urandom)); end
      model_held(1'b0);
      fork drive_host(); drive_loop(); join
      wait_idle("alt_idle");

      bus.host_lock = 1'b1;
      loop_sent = 0;
      repeat (2) begin hq.push_back(16'($urandom)); lq.push_back(16'($urandom)); end
      model_held(1'b1);
      fork drive_loop(); join_none
      drive_host();
      t = 0;
      do begin @(negedge clk); t++; end while ((exp_q.size() > 2 || bus.busy) && t < 5000);
      if (t >= 5000) timeout("lock_host_frames");
      check("loop_granted_under_lock", 32'(loop_sent), 32'd0);
      @(posedge clk); #1;
      bus.host_lock = 1'b0;
      wait fork;
      wait_idle("lock_idle");

      lq.push_back(16'($urandom));
      exp_q.push_back(lq[0]);
      m_last_loop = 1'b1;
      drive_loop();
      repeat (20) @(posedge clk);
      #1 bus.host_lock = 1'b1;
      wait_idle("midlock_idle");
      bus.host_lock = 1'b0;
`endif

      hq.push_back(16'($urandom));
      exp_q.push_back(hq[0]);
      drive_host();
      t = 0;
      do begin @(negedge clk); t++; end while (bus.sync_n && t < 100);
      if (t >= 100) timeout("reset_frame_start");
      repeat (97) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_checks("midrst");
      @(posedge clk); #1;
      reset = 1'b0;
      m_last_loop = 1'b1;
      exp_q.push_back(DFLT);
      wait_idle("rerun_idle");

`ifndef VCXO_DAC_COALESCE_EN
      hq.push_back(16'($urandom));
      lq.push_back(16'($urandom));
      model_held(1'b0);
      fork drive_host(); drive_loop(); join
      wait_idle("tie_idle");
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vcxo_dac_arbiter.md
VCXO_DAC_ARBITER -- requirements
Module: vcxo_dac_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk half-period (legal 2..255).
REQ-002 SHALL have parameter GAP_CYC, default 8, minimum clk cycles sync_n stays high between frames (legal 1..255).
REQ-003 SHALL have parameter DFLT, default 16'h7FFF, DAC code sent automatically after reset.
REQ-004 SHALL have port clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports loop_valid in 1, loop_dat in 16, loop_ready out 1: control-loop DAC write request.
REQ-006 SHALL have ports host_valid in 1, host_dat in 16, host_ready out 1: register-interface DAC write request.
REQ-007 SHALL have port host_lock  in  1  when high, loop requests are never granted.
REQ-008 SHALL have ports sclk out 1, mosi out 1, sync_n out 1: AD5662 serial bus.
REQ-009 SHALL have ports busy out 1 (frame or gap in progress) and last_dat out 16 (code of last completed frame).

Function
REQ-010 SHALL transfer a request in a cycle where its valid and ready are both high; requester holds data stable while valid.
REQ-011 SHALL use FSM states INIT, IDLE, SHIFT, GAP; INIT loads DFLT and enters SHIFT without a handshake.
REQ-012 In IDLE, SHALL grant one requester per cycle: if only one eligible, grant it; if both, grant the one not granted last (round-robin); ready is high only in the grant cycle.
REQ-013 SHALL latch the granted 16-bit code and form a 24-bit frame: 6 zero bits, power-down bits 2'b00, 16 data bits, sent MSB first.
REQ-014 SHALL drive sync_n low on the cycle after grant (cycle N+1) and enter SHIFT.
REQ-015 In SHIFT, sclk SHALL idle high, toggle every CLK_DIV cycles, mosi SHALL change only on sclk rising edges, giving 24 falling edges at which the DAC samples mosi.
REQ-016 SHALL return sync_n high CLK_DIV cycles after the 24th falling edge (frame = 1 + 48*CLK_DIV cycles from grant), update last_dat that cycle, then enter GAP.
REQ-017 GAP SHALL last exactly GAP_CYC cycles with sync_n and sclk high, then enter IDLE.
REQ-018 busy SHALL be high in INIT, SHIFT, GAP and low only in IDLE.
REQ-019 A request arriving during SHIFT/GAP SHALL wait; it is never dropped or reordered within its own port.
REQ-020 host_lock asserted while a loop frame is in SHIFT SHALL NOT abort that frame.
REQ-021 Simultaneous host_valid and loop_valid with host_lock high SHALL grant host regardless of round-robin state, and not update the round-robin pointer.

Reset
REQ-022 While reset is high: sync_n=1, sclk=1, mosi=0, loop_ready=0, host_ready=0, busy=1, last_dat=DFLT, round-robin pointer = loop last granted, state=INIT.
REQ-023 Reset asserted mid-frame SHALL abort the frame (sync_n high next cycle); after release the DFLT frame is resent.

Configuration
REQ-024 With VCXO_DAC_COALESCE_EN defined, loop side SHALL hold a 1-entry pending register: loop_ready=1 whenever not in reset, each accepted loop_dat overwrites the pending value, and the arbiter grants the pending value (clearing pending on grant; a same-cycle new write sets pending again).
REQ-025 Without VCXO_DAC_COALESCE_EN, loop_ready SHALL follow REQ-012 (grant-cycle only, backpressure).

Structure
REQ-026 Package vcxo_dac_pkg SHALL hold FRAME_BITS=24, PD_NORMAL=2'b00, and the FSM state enum.
REQ-027 Serial shifting (sclk divider, bit counter, mosi/sync_n) SHALL be sub-module vcxo_dac_spi_shift with start/done handshake; arbitration stays in the top.

Verification
REQ-028 Release reset, no requests, CLK_DIV=4 -> one frame with data 0x7FFF, sync_n low 193 cycles, then busy low after 8-cycle gap.
REQ-029 loop_valid with 0x1234 in IDLE -> loop_ready 1 cycle, mosi bits 0x001234 MSB first, last_dat=0x1234 at sync_n rise.
REQ-030 host_valid and loop_valid held together, host_lock=0 -> grants alternate host, loop, host; host_lock=1 -> host only, loop_ready stays 0 (non-coalesce build).
REQ-031 Reset pulsed at 100th cycle of a frame -> sync_n high next cycle, new 0x7FFF frame after release.
REQ-032 With VCXO_DAC_COALESCE_EN, loop writes 0x0001, 0x0002, 0x0003 during one busy frame -> next frame carries 0x0003 only.
